// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, mid-bit sampling of a 2-flop synchronised line.
// Define UART_RX_PARITY_EN to expect one even-parity bit between data bit 7 and the stop bit.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned H  = CLKS_PER_BIT / 2;
  localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HI} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
`endif

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [2:0]      bit_idx, bit_idx_nx;
  logic [7:0]      shreg, shreg_nx;
  logic [7:0]      data_nx;
  logic            valid_nx, ferr_nx;
  logic            rx_q1, rx_s;
  logic            half_pt, full_pt;
  logic            par_good;

  assign half_pt = (cnt == CW'(H - 1));
  assign full_pt = (cnt == CW'(CLKS_PER_BIT - 1));
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_ok, par_ok_nx, perr_nx;
  assign par_good = par_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_ok     <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_ok     <= par_ok_nx;
      parity_err <= perr_nx;
    end
  end
`else
  assign par_good   = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bit_idx   <= bit_idx_nx;
      shreg     <= shreg_nx;
      data      <= data_nx;
      valid     <= valid_nx;
      frame_err <= ferr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + CW'(1);
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    data_nx    = data;
    valid_nx   = 1'b0;
    ferr_nx    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_ok_nx  = par_ok;
    perr_nx    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (!rx_s) state_nx = START;
      end
      START: begin
        // Mid-start-bit recheck rejects short low glitches silently.
        if (half_pt) begin
          cnt_nx = '0;
          if (rx_s) begin
            state_nx = IDLE;
          end else begin
            state_nx   = DATA;
            bit_idx_nx = '0;
          end
        end
      end
      DATA: begin
        if (full_pt) begin
          cnt_nx            = '0;
          shreg_nx[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (full_pt) begin
          cnt_nx    = '0;
          par_ok_nx = (rx_s == ^shreg);
          state_nx  = STOP;
        end
      end
`endif
      STOP: begin
        if (full_pt) begin
          cnt_nx = '0;
          if (!rx_s) begin
            ferr_nx  = 1'b1;
            state_nx = WAIT_HI;
          end else if (par_good) begin
            data_nx  = shreg;
            valid_nx = 1'b1;
            state_nx = IDLE;
          end else begin
`ifdef UART_RX_PARITY_EN
            perr_nx  = 1'b1;
`endif
            state_nx = IDLE;
          end
        end
      end
      WAIT_HI: begin
        cnt_nx = '0;
        if (rx_s) state_nx = IDLE;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: byte scoreboard, strobe counters and latency check.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid = 0, n_ferr = 0, n_perr = 0;
  int last_valid_cyc = 0;
  logic [7:0] exp_q[$];

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data(data), .valid(valid),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [7:0] e;
    if (valid || frame_err || parity_err) begin
      checks++;
      if ((int'(valid) + int'(frame_err) + int'(parity_err)) > 1) begin
        errors++;
        $display("FAIL strobe_exclusive: valid=%b frame_err=%b parity_err=%b, required at most one", valid, frame_err, parity_err);
      end
    end
    if (frame_err) n_ferr++;
    if (parity_err) n_perr++;
    if (valid) begin
      n_valid++;
      last_valid_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: data=%h, required no valid", data);
      end else begin
        e = exp_q.pop_front();
        if (data !== e) begin
          errors++;
          $display("FAIL scoreboard_data: got %h, required %h", data, e);
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit,
                            output int start);
    @(negedge clk);
    start = cyc;
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_bit;
    repeat (C) @(negedge clk);
`else
    if (par_bit === 1'bx) rx = 1'b1;
`endif
    rx = stop_bit;
    repeat (C) @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d bytes still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, required 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b, required 0", parity_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b, required 0", busy); end
    checks++;
    if (n_valid + n_ferr + n_perr != 0) begin
      errors++;
      $display("FAIL idle_strobes: got %0d, required 0", n_valid + n_ferr + n_perr);
    end
  endtask

  task automatic test_byte_a5();
    int nv = n_valid;
    int start;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, start);
    wait_drain("a5_drain", 200);
    repeat (10) @(negedge clk);
    checks++; if (n_valid - nv != 1) begin errors++; $display("FAIL a5_count: got %0d, required 1", n_valid - nv); end
    checks++;
    if (last_valid_cyc != start + 3 + 8 + 144) begin
      errors++;
      $display("FAIL a5_latency: got edge %0d, required %0d", last_valid_cyc - start, 3 + 8 + 144);
    end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h, required a5", data); end
  endtask

  task automatic test_glitch();
    int nv = n_valid, nf = n_ferr, np = n_perr;
    logic saw_busy = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    repeat (4) begin @(negedge clk); saw_busy |= busy; end
    rx = 1'b1;
    repeat (30) begin @(negedge clk); saw_busy |= busy; end
    checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_pulse: got %b, required 1", saw_busy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b, required 0", busy); end
    checks++;
    if ((n_valid - nv) + (n_ferr - nf) + (n_perr - np) != 0) begin
      errors++;
      $display("FAIL glitch_strobes: got %0d, required 0", (n_valid - nv) + (n_ferr - nf) + (n_perr - np));
    end
  endtask

  task automatic test_frame_err();
    int nv = n_valid, nf = n_ferr;
    int start;
    send_frame(8'h3C, 1'b0, 1'b0, start);
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (n_ferr - nf != 1) begin errors++; $display("FAIL ferr_count: got %0d, required 1", n_ferr - nf); end
    checks++; if (n_valid != nv) begin errors++; $display("FAIL ferr_valid: got %0d, required 0", n_valid - nv); end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL ferr_data_held: got %h, required a5", data); end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0, start);
    wait_drain("recover_drain", 200);
    checks++; if (data !== 8'h81) begin errors++; $display("FAIL recover_data: got %h, required 81", data); end
  endtask

  task automatic test_reset_abort();
    int nv, nf, np;
    int start;
    @(negedge clk);
    nv = n_valid; nf = n_ferr; np = n_perr;
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = (8'h55 >> i) & 8'h01;
      repeat (C) @(negedge clk);
    end
    rx = 1'b0;
    repeat (C / 2) @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if ((n_valid - nv) + (n_ferr - nf) + (n_perr - np) != 0) begin
      errors++;
      $display("FAIL abort_strobes: got %0d, required 0", (n_valid - nv) + (n_ferr - nf) + (n_perr - np));
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, required 0", busy); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL abort_data_cleared: got %h, required 00", data); end
    nv = n_valid;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0, start);
    wait_drain("abort_resend_drain", 200);
    checks++; if (n_valid - nv != 1) begin errors++; $display("FAIL abort_resend_count: got %0d, required 1", n_valid - nv); end
    checks++; if (data !== 8'h55) begin errors++; $display("FAIL abort_resend_data: got %h, required 55", data); end
  endtask

  task automatic test_back_to_back();
    int nv = n_valid;
    int start;
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'hF0);
    send_frame(8'h0F, 1'b1, 1'b0, start);
    send_frame(8'hF0, 1'b1, 1'b0, start);
    wait_drain("b2b_drain", 200);
    checks++; if (n_valid - nv != 2) begin errors++; $display("FAIL b2b_count: got %0d, required 2", n_valid - nv); end
    checks++; if (data !== 8'hF0) begin errors++; $display("FAIL b2b_data: got %h, required f0", data); end
  endtask

  task automatic test_parity();
    int nv = n_valid, np = n_perr;
    int start;
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, start);
    repeat (20) @(negedge clk);
    checks++; if (n_perr - np != 1) begin errors++; $display("FAIL parity_bad_count: got %0d, required 1", n_perr - np); end
    checks++; if (n_valid != nv) begin errors++; $display("FAIL parity_bad_valid: got %0d, required 0", n_valid - nv); end
    checks++; if (data !== 8'hF0) begin errors++; $display("FAIL parity_bad_data_held: got %h, required f0", data); end
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, start);
    wait_drain("parity_good_drain", 200);
    checks++; if (data !== 8'h07) begin errors++; $display("FAIL parity_good_data: got %h, required 07", data); end
    checks++; if (n_perr - np != 1) begin errors++; $display("FAIL parity_good_perr: got %0d, required 1", n_perr - np); end
`else
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0, start);
    wait_drain("noparity_drain", 200);
    checks++; if (n_perr != np) begin errors++; $display("FAIL noparity_perr: got %0d, required 0", n_perr - np); end
    checks++; if (n_valid - nv != 1) begin errors++; $display("FAIL noparity_count: got %0d, required 1", n_valid - nv); end
`endif
  endtask

  initial begin
    test_reset();
    test_byte_a5();
    test_glitch();
    test_frame_err();
    test_reset_abort();
    test_back_to_back();
    test_parity();
    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
